// File: rtl/i2c_target_model.sv
// rtl/i2c_target_model.sv - I2C register-file target that ACKs, accepts writes and returns read data.
module i2c_target_model #(
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         NumRegs    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_oe_o,
    output logic                       busy_o,
    output logic                       wr_valid_o,
    output logic [$clog2(NumRegs)-1:0] wr_addr_o,
    output logic [7:0]                 wr_data_o
);

    localparam int AW = $clog2(NumRegs);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RD_ACK,
        S_IGNORE
    } state_e;

    state_e         state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic           rw;
    logic [AW-1:0]  ptr;
    logic [AW-1:0]  ptr_next;
    logic [7:0]     regs [NumRegs];

    // [0] first sync stage, [1] synchronised level, [2] previous synchronised level
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_q[1] & sda_q[1] & ~sda_q[2];
    assign rx_byte   = {shift[6:0], sda_q[1]};
    assign ptr_next  = ptr + AW'(1);

    // Bus conditions take priority over any SCL edge seen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rw         <= 1'b0;
            ptr        <= '0;
            sda_oe_o   <= 1'b0;
            busy_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_valid_o <= 1'b0;
            if (stop_det) begin
                state    <= S_IDLE;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
            end else begin
                unique case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                rw      <= sda_q[1];
                                if (rx_byte[7:1] == TargetAddr) begin
                                    state  <= S_ADDR_ACK;
                                    busy_o <= 1'b1;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // Ack states: first fall pulls SDA low, second fall ends the ack bit.
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe_o <= 1'b1;
                                bit_cnt  <= 4'd1;
                            end else if (rw) begin
                                sda_oe_o <= ~regs[ptr][7];
                                shift    <= {regs[ptr][6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                                state    <= S_RDATA;
                            end else begin
                                sda_oe_o <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                ptr     <= rx_byte[AW-1:0];
                                bit_cnt <= '0;
                                state   <= S_PTR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe_o <= 1'b1;
                                bit_cnt  <= 4'd1;
                            end else begin
                                sda_oe_o <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                regs[ptr]  <= rx_byte;
                                wr_valid_o <= 1'b1;
                                wr_addr_o  <= ptr;
                                wr_data_o  <= rx_byte;
                                ptr        <= ptr_next;
                                bit_cnt    <= '0;
                                state      <= S_WDATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // bit_cnt counts bits already placed on SDA.
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_o <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= S_RD_ACK;
                            end else begin
                                sda_oe_o <= ~shift[7];
                                shift    <= {shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr_next;
                            if (!sda_q[1]) begin
                                shift   <= regs[ptr_next];
                                bit_cnt <= '0;
                                state   <= S_RDATA;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        sda_oe_o <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        sda_oe_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
